// File: rtl/chacha20_block_seq.sv
// ChaCha20 block function, iterative: one column or diagonal round per cycle.
// A block is captured on start, run for ROUNDS single rounds, then the
// original state is added back and the result is held on keystream until the
// consumer takes it.
//
// Handshake: out_valid is high exactly while a finished block is held and
// keystream does not change while it is high; the block is taken on the
// rising clock edge where out_valid and out_ready are both 1, after which
// out_valid drops. start is a request that is only looked at while idle
// (busy=0); it is not a valid/ready channel and is never back-pressured.
module chacha20_block_seq #(
  parameter int num_bits = 32,
  parameter int ROUNDS   = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*num_bits-1:0]   key,
  input  logic [3*num_bits-1:0]   nonce,
  input  logic [num_bits-1:0]     counter,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*num_bits-1:0]  keystream
);

  localparam int RCW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Current FSM state; kept as a plain named register so checkers can bind to it.
  state_t              state;
  logic [RCW-1:0]      rnd;
  logic [num_bits-1:0] work   [16];
  logic [num_bits-1:0] orig   [16];
  logic [num_bits-1:0] init_w [16];
  logic [num_bits-1:0] next_w [16];
  logic                last_round;

  function automatic logic [num_bits-1:0] rotl(input logic [num_bits-1:0] x,
                                               input int n);
    return (x << n) | (x >> (num_bits - n));
  endfunction

  // One quarter round; returns {a, b, c, d}.
  function automatic logic [4*num_bits-1:0] qr(input logic [num_bits-1:0] a_in,
                                               input logic [num_bits-1:0] b_in,
                                               input logic [num_bits-1:0] c_in,
                                               input logic [num_bits-1:0] d_in);
    logic [num_bits-1:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = rotl(d, 16);
    c = c + d; b = b ^ c; b = rotl(b, 12);
    a = a + b; d = d ^ a; d = rotl(d, 8);
    c = c + d; b = b ^ c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  assign last_round = (rnd == RCW'(ROUNDS - 1));

  // Initial state layout: constants, key, block counter, nonce.
  always_comb begin
    init_w[0]  = 32'h61707865;
    init_w[1]  = 32'h3320646e;
    init_w[2]  = 32'h79622d32;
    init_w[3]  = 32'h6b206574;
    for (int i = 0; i < 8; i++) init_w[4+i] = key[num_bits*i +: num_bits];
    init_w[12] = counter;
    for (int i = 0; i < 3; i++) init_w[13+i] = nonce[num_bits*i +: num_bits];
  end

  // Next working state: four parallel quarter rounds, column on even rounds,
  // diagonal on odd. Quad i of the diagonal set walks one column to the right
  // per row, wrapping within the row.
  always_comb begin
    next_w = work;
    for (int i = 0; i < 4; i++) begin
      if (!rnd[0]) begin
        {next_w[i], next_w[4+i], next_w[8+i], next_w[12+i]} =
          qr(work[i], work[4+i], work[8+i], work[12+i]);
      end else begin
        {next_w[i], next_w[4+((i+1)%4)], next_w[8+((i+2)%4)], next_w[12+((i+3)%4)]} =
          qr(work[i], work[4+((i+1)%4)], work[8+((i+2)%4)], work[12+((i+3)%4)]);
      end
    end
  end

  // Control FSM with registered busy/out_valid and the keystream register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      keystream <= '0;
      for (int i = 0; i < 16; i++) begin
        work[i] <= '0;
        orig[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= init_w;
            orig  <= init_w;
            rnd   <= '0;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          work <= next_w;
          rnd  <= rnd + 1'b1;
          if (last_round) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 16; i++)
            keystream[num_bits*i +: num_bits] <= work[i] + orig[i];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // keystream is left untouched so the last block stays readable.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_block_seq.sv
// Directed + randomized bench for chacha20_block_seq with a reference model
// of the ChaCha20 block function written as plain double rounds.
module tb_chacha20_block_seq;

  localparam int ROUNDS = 20;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] keystream;

  int tests = 0;
  int fails = 0;
  logic [511:0] exp_q[$];

  chacha20_block_seq #(.num_bits(32), .ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .nonce     (nonce),
    .counter   (counter),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .keystream (keystream)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [127:0] mqr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a += b; d = rl(d ^ a, 16);
    c += d; b = rl(b ^ c, 12);
    a += b; d = rl(d ^ a, 8);
    c += d; b = rl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] model(input logic [255:0] k, input logic [95:0] n,
                                         input logic [31:0] c);
    logic [31:0] s[16];
    logic [31:0] x[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int dr = 0; dr < ROUNDS / 2; dr++) begin
      {x[0], x[4], x[8],  x[12]} = mqr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = mqr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = mqr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = mqr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = mqr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = mqr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = mqr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = mqr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // Checker
  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge and records the expected block.
  task automatic issue(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    key = k; nonce = n; counter = c; start = 1'b1;
    exp_q.push_back(model(k, n, c));
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for out_valid; lat counts edges since the call.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_valid_seen"}, out_valid, 1);
  endtask

  task automatic check_block(input string tag);
    logic [511:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, keystream, e);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_low"}, out_valid, 0);
  endtask

  function automatic logic [255:0] rfc_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++)
      k[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    return k;
  endfunction

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Stimulus
  initial begin
    int lat;
    int gap;
    int bad;
    logic [511:0] snap;
    logic [255:0] k0;
    logic [95:0]  n0;
    logic [95:0]  rfc_nonce;

    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    key = '0; nonce = '0; counter = '0;

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ks", keystream, 0);
    #20;
    rst = 1'b0;
    tick();

    // Known-answer vector, latency and busy
    issue(rfc_key(), rfc_nonce, 32'd1);
    check("rfc_busy", busy, 1);
    wait_valid("rfc", lat);
    check("rfc_latency", lat, ROUNDS + 1);
    check("rfc_w0", keystream[31:0], 32'he4e7f110);
    check("rfc_w1", keystream[63:32], 32'h15593bd1);
    check("rfc_w2", keystream[95:64], 32'h1fdd0f50);
    check("rfc_w3", keystream[127:96], 32'hc47120a3);
    check("rfc_w15", keystream[511:480], 32'h4e3c50a2);
    check_block("rfc_full");
    handshake("rfc");
    check("rfc_hold_after", keystream[31:0], 32'he4e7f110);
    check("rfc_idle", busy, 0);

    // All-zero inputs
    issue('0, '0, 32'd0);
    wait_valid("zero", lat);
    check("zero_w0", keystream[31:0], 32'hade0b876);
    check("zero_w1", keystream[63:32], 32'h903df1a0);
    check_block("zero_full");
    handshake("zero");

    // Stall for 50 cycles with start pulses
    issue(rnd_key(), {$urandom, $urandom, $urandom}, $urandom);
    wait_valid("stall", lat);
    snap = keystream;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      start = 1'($urandom_range(0, 1));
      key = rnd_key();
      tick();
      if (out_valid !== 1'b1 || keystream !== snap || busy !== 1'b1) bad++;
    end
    check("stall_stable_cycles", bad, 0);
    check_block("stall_full");
    // start in the handshake cycle must be ignored
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("hs_start_ignored_valid", out_valid, 0);
    check("hs_start_ignored_busy", busy, 0);
    check("hs_ks_held", keystream, snap);
    tick();
    check("hs_still_idle", busy, 0);

    // Reset at round 7
    issue(rnd_key(), {$urandom, $urandom, $urandom}, $urandom);
    repeat (7) tick();
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_ks", keystream, 0);
    void'(exp_q.pop_back());
    repeat (3) tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_no_output", bad, 0);
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    issue(rfc_key(), rfc_nonce, 32'd1);
    wait_valid("restart", lat);
    check("restart_latency", lat, ROUNDS + 1);
    check("restart_w15", keystream[511:480], 32'h4e3c50a2);
    check_block("restart_full");
    handshake("restart");

    // Back-to-back with start held; consumer answers one cycle after it
    // sees out_valid, so the second block lands ROUNDS+4 cycles later.
    k0 = rnd_key();
    n0 = {$urandom, $urandom, $urandom};
    key = k0; nonce = n0; counter = 32'd1; start = 1'b1;
    exp_q.push_back(model(k0, n0, 32'd1));
    tick();
    counter = 32'd2;
    exp_q.push_back(model(k0, n0, 32'd2));
    wait_valid("b2b1", lat);
    check("b2b1_latency", lat, ROUNDS + 1);
    check_block("b2b1_full");
    tick();
    handshake("b2b1");
    gap = 2;
    while (!out_valid && gap < 100) begin
      tick();
      gap++;
    end
    start = 1'b0;
    check("b2b_gap", gap, ROUNDS + 4);
    check_block("b2b2_full");
    handshake("b2b2");

    // Inputs changed one cycle after start
    k0 = rnd_key();
    n0 = {$urandom, $urandom, $urandom};
    issue(k0, n0, 32'd7);
    key = ~k0; nonce = ~n0; counter = 32'd99;
    tick();
    key = rnd_key();
    wait_valid("capture", lat);
    check_block("capture_full");
    handshake("capture");

    // Random blocks with random consumer delay
    for (int t = 0; t < 6; t++) begin
      issue(rnd_key(), {$urandom, $urandom, $urandom}, $urandom);
      wait_valid("rand", lat);
      check("rand_latency", lat, ROUNDS + 1);
      repeat ($urandom_range(0, 4)) tick();
      check_block("rand_full");
      handshake("rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    check("sb_drained", exp_q.size(), 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chacha20_block_seq.md
CHACHA20_BLOCK_SEQ -- requirements
Module: chacha20_block_seq

Interface
REQ-001 SHALL have parameter num_bits, default 32: width of one state word; only 32 is supported.
REQ-002 SHALL have parameter ROUNDS, default 20: total single rounds (column or diagonal); only even values of 2 or more are legal.
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a keystream block; sampled only in IDLE.
REQ-006 SHALL have port key, input, 256: key[32*i+31:32*i] is state word 4+i (i=0..7).
REQ-007 SHALL have port nonce, input, 96: nonce[32*i+31:32*i] is state word 13+i (i=0..2).
REQ-008 SHALL have port counter, input, 32: block counter, state word 12.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port out_valid, output, 1: keystream holds a finished block.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the block.
REQ-012 SHALL have port keystream, output, 512: keystream[32*i+31:32*i] is final word i (i=0..15).

Function
REQ-013 SHALL build the initial state as: words 0-3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; words 4-11 = key; word 12 = counter; words 13-15 = nonce.
REQ-014 SHALL implement FSM states IDLE, ROUND, FINAL and DONE.
REQ-015 SHALL, on IDLE with start=1 at edge N, capture the initial state into both a working register and an original-state register, clear the round counter to 0, and enter ROUND.
REQ-016 SHALL ignore start in ROUND, FINAL and DONE; inputs captured at edge N are not affected by later key, nonce or counter changes.
REQ-017 SHALL, in ROUND, apply four parallel 32-bit quarter rounds to the working state each cycle.
REQ-017a Even round-counter values SHALL use column quads (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
REQ-017b Odd round-counter values SHALL use diagonal quads (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
REQ-018 Each quarter round SHALL compute, all mod 2^32 with left rotates: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
REQ-019 SHALL increment the round counter each ROUND cycle and enter FINAL after the round with counter value ROUNDS-1 (edge N+ROUNDS).
REQ-020 SHALL, in FINAL, register keystream word i = working word i + original word i (mod 2^32, carry discarded) and enter DONE at edge N+ROUNDS+1.
REQ-021 SHALL hold out_valid high exactly while in DONE, with keystream stable throughout.
REQ-022 SHALL, in DONE with out_ready=1 at an edge, return to IDLE and drive out_valid low after that edge; out_ready outside DONE has no effect.
REQ-023 SHALL ignore a start asserted in the same cycle as the out_ready handshake; start is honoured only from the following IDLE cycle.
REQ-024 SHALL keep keystream holding the last block after the handshake until the next FINAL overwrites it.
REQ-025 SHALL give a start-to-out_valid latency of ROUNDS+1 cycles (21 at default) and a minimum issue interval of ROUNDS+3 cycles.
REQ-026 SHALL contain no combinational path from any input to busy, out_valid or keystream.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for a clock edge, force IDLE and drive busy=0, out_valid=0, keystream=0, round counter=0, working and original registers=0.
REQ-028 rst asserted mid-ROUND or in DONE SHALL abort the block with no output produced; start SHALL be honoured from the first edge after rst deasserts.

Verification
REQ-029 Bench SHALL cover key words 0x03020100..0x1f1e1d1c, nonce words 0x09000000, 0x4a000000, 0x00000000, counter=1 -> after 21 cycles, words 0-3 = e4e7f110 15593bd1 1fdd0f50 c47120a3 and word 15 = 4e3c50a2.
REQ-030 Bench SHALL cover all-zero key, nonce and counter -> word 0 = 0xade0b876, word 1 = 0x903df1a0.
REQ-031 Bench SHALL cover out_ready held low for 50 cycles -> out_valid and keystream stable for all 50 cycles, busy=1, repeated start pulses ignored.
REQ-032 Bench SHALL cover rst pulsed at round 7 -> outputs zero immediately, no out_valid; a restart yields the correct full vector.
REQ-033 Bench SHALL cover back-to-back blocks, counter 1 then 2, with start held high -> second out_valid exactly 24 cycles after the first.
REQ-034 Bench SHALL cover key/nonce changed one cycle after start -> output equals the vector for the originally captured inputs.
